bist_fail_log: RTL and testbench
================================

BIST_FAIL_LOG -- requirements
Module: bist_fail_log

Interface
REQ-001 SHALL have parameter AW, default 4, address width of the memory under test.
REQ-002 SHALL have parameter DW, default 8, data width of the memory under test.
REQ-003 SHALL have parameter DEPTH, default 8, fail-log entries; power of two, minimum 2.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 start  input  1  test-start pulse from the BIST controller; synchronous clear of the log.
REQ-007 rd_en  input  1  controller read strobe; memory read data follows one cycle later.
REQ-008 exp_bit  input  1  expected background bit; replicated across DW for comparison.
REQ-009 addr  input  AW  address being read.
REQ-010 phase  input  3  controller march-phase code, sampled with rd_en.
REQ-011 mem_q  input  DW  memory read data, valid the cycle after rd_en.
REQ-012 is_equal  output  1  compare result to the controller; 1 when no compare is active.
REQ-013 any_fail  output  1  high while fail_cnt is non-zero.
REQ-014 fail_cnt  output  8  saturating mismatch count.
REQ-015 overflow  output  1  sticky; a mismatch was dropped because the log was full.
REQ-016 log_valid  output  1  head log entry available.
REQ-017 log_ready  input  1  consumer accepts the head entry.
REQ-018 log_phase / log_addr / log_syn  output  3 / AW / DW  head entry fields; log_syn is the bitwise XOR of expected and observed data.

Function
REQ-019 SHALL, on a cycle N with rd_en high, register addr, exp_bit and phase into a one-entry compare stage marked valid.
REQ-020 SHALL, in cycle N+1, compare mem_q against DW copies of the staged exp_bit; is_equal is combinational from this compare.
REQ-021 SHALL, on a mismatch in cycle N+1, push {phase, addr, syndrome} at the end of N+1; log_valid is high no earlier than N+2.
REQ-022 SHALL increment fail_cnt once per mismatching compare and saturate at 255 without wrapping.
REQ-023 SHALL drop the entry when the log is full and no pop occurs that cycle, set overflow, and still increment fail_cnt.
REQ-024 SHALL pop when log_valid and log_ready are both high; log_ready is ignored while log_valid is low.
REQ-025 SHALL, when full with a simultaneous push and pop, perform both, leave occupancy unchanged, and not set overflow.
REQ-026 SHALL, when empty with a push, keep log_valid low that cycle; the entry is not bypassed.
REQ-027 SHALL hold the log_* fields stable while log_valid is high and log_ready is low.
REQ-028 SHALL, on start high, clear the log, fail_cnt, overflow and the compare stage; start overrides a push or pop in the same cycle.
REQ-029 SHALL wrap the read and write pointers modulo DEPTH, using an extra pointer bit to distinguish full from empty.

Reset
REQ-030 SHALL, while rst is asserted, force is_equal=1, any_fail=0, fail_cnt=0, overflow=0, log_valid=0 and log_* fields to 0, with the log empty and the compare stage invalid.
REQ-031 SHALL discard an in-flight compare when rst is asserted mid-test; no entry is pushed for it.

Structure
REQ-032 SHALL take the phase codes (IDLE=0, W0=1, R0=2, W1=3, R1=4) and the entry-field layout from the shared package bist_pkg.
REQ-033 SHALL implement the log storage as one sub-module, bist_fail_fifo, parameterised by entry width and DEPTH, with push/pop/clear ports.

Verification
REQ-034 Scenario 1: rd_en with addr=5, exp_bit=0, then mem_q=8'h10 -> is_equal=0 in the next cycle; a log entry {R0, 5, 8'h10} is present; fail_cnt=1.
REQ-035 Scenario 2: 10 mismatches with log_ready=0 -> 8 entries held, overflow=1, fail_cnt=10; draining the log returns the first 8 addresses in order.
REQ-036 Scenario 3: log full, log_ready=1, plus a mismatch in the same cycle -> occupancy stays 8, overflow=0, the newest entry is at the tail.
REQ-037 Scenario 4: 300 mismatches -> fail_cnt=255; a start pulse then gives fail_cnt=0, log_valid=0, overflow=0.
REQ-038 Scenario 5: rst asserted one cycle after a mismatching rd_en -> after rst release, log empty and fail_cnt=0.
REQ-039 Scenario 6: all reads match (exp_bit=1, mem_q=8'hFF) over the full address range -> is_equal stays 1 and any_fail=0 throughout.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared BIST definitions: march-phase codes and the fail-log entry layout.
package bist_pkg;

    // March-phase codes reported by the BIST controller.
    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_W0   = 3'd1,
        PH_R0   = 3'd2,
        PH_W1   = 3'd3,
        PH_R1   = 3'd4
    } phase_e;

    // Width of the phase field in a log entry.
    localparam int PHASE_W = 3;

    // Fail-log entry layout, MSB to LSB: {phase, addr, syndrome}.
    // The address and syndrome widths follow the memory under test.
    function automatic int entry_w(input int aw, input int dw);
        return PHASE_W + aw + dw;
    endfunction

endpackage

// File: rtl/bist_fail_log_if.sv
// Bundle of the controller-side and log-consumer-side signals of bist_fail_log.
interface bist_fail_log_if
    import bist_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic               start;
    logic               rd_en;
    logic               exp_bit;
    logic [AW-1:0]      addr;
    logic [PHASE_W-1:0] phase;
    logic [DW-1:0]      mem_q;
    logic               is_equal;
    logic               any_fail;
    logic [7:0]         fail_cnt;
    logic               overflow;
    logic               log_valid;
    logic               log_ready;
    logic [PHASE_W-1:0] log_phase;
    logic [AW-1:0]      log_addr;
    logic [DW-1:0]      log_syn;

    // Controller / consumer side.
    modport master (
        output start, rd_en, exp_bit, addr, phase, mem_q, log_ready,
        input  is_equal, any_fail, fail_cnt, overflow,
               log_valid, log_phase, log_addr, log_syn
    );

    // Fail-log side.
    modport slave (
        input  start, rd_en, exp_bit, addr, phase, mem_q, log_ready,
        output is_equal, any_fail, fail_cnt, overflow,
               log_valid, log_phase, log_addr, log_syn
    );
endinterface

// File: rtl/bist_fail_fifo.sv
// Fail-log storage: synchronous FIFO with an extra pointer bit for full/empty.
module bist_fail_fifo #(
    parameter int W     = 15,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    // A pop frees the slot the same cycle, so a full FIFO can still accept a push.
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && (!full || do_pop) && !clear;

    assign dout = mem[rd_ptr[PW-1:0]];

    // Pointer update; clear returns both pointers to zero.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Entry storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; empty pointers make stale contents unobservable.
        if (do_push) mem[wr_ptr[PW-1:0]] <= din;
    end
endmodule

// File: rtl/bist_fail_log.sv
// BIST compare stage, saturating fail counter and fail-entry log.
module bist_fail_log
    import bist_pkg::*;
#(
    parameter int AW    = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input logic           clk,
    input logic           rst,
    bist_fail_log_if.slave bus
);
    localparam int EW = entry_w(AW, DW);

    logic               stg_valid;
    logic               stg_exp;
    logic [AW-1:0]      stg_addr;
    logic [PHASE_W-1:0] stg_phase;
    logic [DW-1:0]      syn;
    logic               mismatch;
    logic               pop;
    logic               full;
    logic               empty;
    logic [EW-1:0]      head;
    logic [7:0]         cnt;
    logic               ovf;

    // Syndrome is the bitwise difference between expected background and read data.
    assign syn      = bus.mem_q ^ {DW{stg_exp}};
    assign mismatch = stg_valid && (syn != '0);
    assign pop      = !empty && bus.log_ready;

    assign bus.is_equal  = !mismatch;
    assign bus.fail_cnt  = cnt;
    assign bus.any_fail  = (cnt != 8'd0);
    assign bus.overflow  = ovf;
    assign bus.log_valid = !empty;
    // Fields read as zero whenever no entry is presented.
    assign {bus.log_phase, bus.log_addr, bus.log_syn} = empty ? '0 : head;

    // Compare stage: captures read context so it lines up with next-cycle read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || bus.start) begin
            stg_valid <= 1'b0;
            stg_exp   <= 1'b0;
            stg_addr  <= '0;
            stg_phase <= '0;
        end else begin
            stg_valid <= bus.rd_en;
            if (bus.rd_en) begin
                stg_exp   <= bus.exp_bit;
                stg_addr  <= bus.addr;
                stg_phase <= bus.phase;
            end
        end
    end

    // Saturating mismatch count and sticky overflow for entries dropped on a full log.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 8'd0;
            ovf <= 1'b0;
        end else if (bus.start) begin
            cnt <= 8'd0;
            ovf <= 1'b0;
        end else if (mismatch) begin
            if (cnt != 8'hFF) cnt <= cnt + 8'd1;
            if (full && !pop)  ovf <= 1'b1;
        end
    end

    bist_fail_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.start),
        .push  (mismatch),
        .pop   (pop),
        .din   ({stg_phase, stg_addr, syn}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: tb/tb_bist_fail_log.sv
// Directed self-checking bench for bist_fail_log.
module tb_bist_fail_log;
    import bist_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bist_fail_log_if #(.AW(4), .DW(8)) bus ();

    bist_fail_log #(.AW(4), .DW(8), .DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a read, then present read data in the compare cycle; returns with the
    // compare active (before the edge that commits it).
    task automatic read_cmp(input logic [3:0] a, input logic e, input logic [2:0] p,
                            input logic [7:0] d);
        bus.rd_en   = 1'b1;
        bus.addr    = a;
        bus.exp_bit = e;
        bus.phase   = p;
        tick();
        bus.rd_en = 1'b0;
        bus.mem_q = d;
        #1;
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.rd_en     = 1'b0;
        bus.exp_bit   = 1'b0;
        bus.addr      = '0;
        bus.phase     = PH_IDLE;
        bus.mem_q     = '0;
        bus.log_ready = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst_is_equal",  bus.is_equal, 1);
        check("rst_any_fail",  bus.any_fail, 0);
        check("rst_fail_cnt",  bus.fail_cnt, 0);
        check("rst_overflow",  bus.overflow, 0);
        check("rst_log_valid", bus.log_valid, 0);
        check("rst_log_fields", {bus.log_phase, bus.log_addr, bus.log_syn}, 0);
        rst = 1'b0;
        tick();

        // Scenario 1: single mismatch at addr 5.
        read_cmp(4'd5, 1'b0, PH_R0, 8'h10);
        check("s1_is_equal", bus.is_equal, 0);
        check("s1_no_bypass", bus.log_valid, 0);
        tick();
        check("s1_log_valid", bus.log_valid, 1);
        check("s1_log_phase", bus.log_phase, 2);
        check("s1_log_addr",  bus.log_addr, 5);
        check("s1_log_syn",   bus.log_syn, 8'h10);
        check("s1_fail_cnt",  bus.fail_cnt, 1);
        check("s1_any_fail",  bus.any_fail, 1);
        check("s1_idle_equal", bus.is_equal, 1);
        bus.log_ready = 1'b1;
        tick();
        bus.log_ready = 1'b0;
        check("s1_popped", bus.log_valid, 0);
        start_pulse();

        // Scenario 2: 10 mismatches with no consumer.
        for (int i = 0; i < 10; i++) begin
            read_cmp(4'(i), 1'b0, PH_R0, 8'(i + 1));
            tick();
        end
        check("s2_fail_cnt", bus.fail_cnt, 10);
        check("s2_overflow", bus.overflow, 1);
        tick();
        check("s2_hold_addr", bus.log_addr, 0);
        check("s2_hold_syn",  bus.log_syn, 1);
        bus.log_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("s2_drain_valid", bus.log_valid, 1);
            check("s2_drain_addr",  bus.log_addr, i);
            check("s2_drain_syn",   bus.log_syn, i + 1);
            tick();
        end
        check("s2_empty", bus.log_valid, 0);
        bus.log_ready = 1'b0;
        check("s2_ovf_sticky", bus.overflow, 1);
        start_pulse();

        // Scenario 3: full log with simultaneous push and pop.
        for (int i = 0; i < 8; i++) begin
            read_cmp(4'(i), 1'b1, PH_R1, 8'h00);
            tick();
        end
        check("s3_full_overflow", bus.overflow, 0);
        read_cmp(4'd12, 1'b1, PH_R1, 8'h7F);
        bus.log_ready = 1'b1;
        tick();
        bus.log_ready = 1'b0;
        check("s3_overflow", bus.overflow, 0);
        check("s3_fail_cnt", bus.fail_cnt, 9);
        bus.log_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            check("s3_drain_addr", bus.log_addr, i);
            tick();
        end
        check("s3_tail_valid", bus.log_valid, 1);
        check("s3_tail_addr",  bus.log_addr, 12);
        check("s3_tail_syn",   bus.log_syn, 8'h80);
        check("s3_tail_phase", bus.log_phase, 4);
        tick();
        check("s3_empty", bus.log_valid, 0);
        bus.log_ready = 1'b0;
        start_pulse();

        // Scenario 4: saturation, then start clears; start also beats a same-cycle push.
        for (int i = 0; i < 300; i++) begin
            read_cmp(4'(i), 1'b0, PH_R0, 8'h01);
            tick();
        end
        check("s4_saturate", bus.fail_cnt, 255);
        check("s4_overflow", bus.overflow, 1);
        start_pulse();
        check("s4_clr_cnt",      bus.fail_cnt, 0);
        check("s4_clr_valid",    bus.log_valid, 0);
        check("s4_clr_overflow", bus.overflow, 0);
        check("s4_clr_any_fail", bus.any_fail, 0);
        read_cmp(4'd3, 1'b0, PH_R0, 8'h04);
        start_pulse();
        check("s4_start_wins_cnt",   bus.fail_cnt, 0);
        check("s4_start_wins_valid", bus.log_valid, 0);

        // Scenario 5: reset while a mismatching compare is in flight.
        read_cmp(4'd9, 1'b0, PH_R0, 8'hA5);
        rst = 1'b1;
        #1;
        check("s5_rst_is_equal", bus.is_equal, 1);
        tick();
        rst       = 1'b0;
        bus.mem_q = 8'h00;
        tick();
        check("s5_log_valid", bus.log_valid, 0);
        check("s5_fail_cnt",  bus.fail_cnt, 0);

        // Scenario 6: every read matches across the address range.
        for (int a = 0; a < 16; a++) begin
            read_cmp(4'(a), 1'b1, PH_R1, 8'hFF);
            check("s6_is_equal", bus.is_equal, 1);
            tick();
            check("s6_any_fail", bus.any_fail, 0);
        end
        check("s6_log_valid", bus.log_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
